exc_ctrl: RTL and testbench

EXC_CTRL -- requirements
Module: exc_ctrl

---
 rtl/exc_ctrl.sv | 135 +++++++++++++
 tb/tb_exc_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/exc_ctrl.sv
// Exception/ERET controller at the MEM commit point: prioritises faults and interrupts,
// drives cp0 exception updates, and holds a flush + fetch redirect until fetch accepts it.
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_stall,
    input  logic [31:0] mem_pc,
    input  logic        mem_bd,
    input  logic        f_adel,
    input  logic        f_tlb_miss,
    input  logic        ri,
    input  logic        sys,
    input  logic        bp,
    input  logic        ov,
    input  logic        d_adel,
    input  logic        d_ades,
    input  logic        d_tlbl,
    input  logic        d_tlbs,
    input  logic [31:0] mem_badvaddr,
    input  logic        eret,
    input  logic [7:0]  interrupt_flag,
    input  logic        allow_int,
    input  logic [31:0] epc,
    output logic        en_exp_o,
    output logic        exp_bd,
    output logic        exp_badvaddr_we,
    output logic        clear_exl,
    output logic [4:0]  exc_code,
    output logic [31:0] exp_epc,
    output logic [31:0] exp_badvaddr,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready
);

    typedef enum logic {IDLE, REDIRECT} state_t;
    state_t state;

    logic        commit;
    logic        take_int;
    logic        any_exc;
    logic [4:0]  code;
    logic        bv_we;
    logic [31:0] bv;

    assign commit = (state == IDLE) && mem_valid && !mem_stall;

    // Priority chain; only address-class faults report a bad virtual address.
    always_comb begin
        take_int = allow_int && (|interrupt_flag);
        any_exc  = take_int | f_adel | f_tlb_miss | ri | sys | bp | ov |
                   d_adel | d_ades | d_tlbl | d_tlbs;
        code     = 5'd0;
        bv_we    = 1'b0;
        bv       = mem_badvaddr;
        if (take_int) begin
            code = 5'd0;
        end else if (f_adel) begin
            code = 5'd4;  bv_we = 1'b1; bv = mem_pc;
        end else if (f_tlb_miss) begin
            code = 5'd2;  bv_we = 1'b1; bv = mem_pc;
        end else if (ri) begin
            code = 5'd10;
        end else if (sys) begin
            code = 5'd8;
        end else if (bp) begin
            code = 5'd9;
        end else if (ov) begin
            code = 5'd12;
        end else if (d_adel) begin
            code = 5'd4;  bv_we = 1'b1;
        end else if (d_ades) begin
            code = 5'd5;  bv_we = 1'b1;
        end else if (d_tlbl) begin
            code = 5'd2;  bv_we = 1'b1;
        end else if (d_tlbs) begin
            code = 5'd3;  bv_we = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            en_exp_o        <= 1'b0;
            exp_bd          <= 1'b0;
            exp_badvaddr_we <= 1'b0;
            clear_exl       <= 1'b0;
            exc_code        <= 5'd0;
            exp_epc         <= 32'd0;
            exp_badvaddr    <= 32'd0;
            flush           <= 1'b0;
            redirect_valid  <= 1'b0;
            redirect_pc     <= 32'd0;
        end else begin
            en_exp_o        <= 1'b0;
            clear_exl       <= 1'b0;
            exp_badvaddr_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (commit && any_exc) begin
                        en_exp_o        <= 1'b1;
                        exc_code        <= code;
                        exp_bd          <= mem_bd;
                        exp_epc         <= mem_bd ? mem_pc - 32'd4 : mem_pc;
                        exp_badvaddr_we <= bv_we;
                        exp_badvaddr    <= bv;
                        flush           <= 1'b1;
                        redirect_valid  <= 1'b1;
                        redirect_pc     <= EXC_VECTOR;
                        state           <= REDIRECT;
                    end else if (commit && eret) begin
                        clear_exl      <= 1'b1;
                        flush          <= 1'b1;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= epc;
                        state          <= REDIRECT;
                    end
                end
                REDIRECT: begin
                    if (redirect_ready) begin
                        flush          <= 1'b0;
                        redirect_valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: table of commit vectors plus hand-written
// sequences for interrupt deferral, redirect backpressure and async reset.
module tb_exc_ctrl;

    localparam logic [31:0] VEC = 32'hBFC00380;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_stall, mem_bd, eret, allow_int, redirect_ready;
    logic [31:0] mem_pc, mem_badvaddr, epc;
    logic [9:0]  fl;
    logic [7:0]  interrupt_flag;
    logic        en_exp_o, exp_bd, exp_badvaddr_we, clear_exl, flush, redirect_valid;
    logic [4:0]  exc_code;
    logic [31:0] exp_epc, exp_badvaddr, redirect_pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exc_ctrl #(.EXC_VECTOR(VEC)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_stall(mem_stall), .mem_pc(mem_pc), .mem_bd(mem_bd),
        .f_adel(fl[9]), .f_tlb_miss(fl[8]), .ri(fl[7]), .sys(fl[6]), .bp(fl[5]),
        .ov(fl[4]), .d_adel(fl[3]), .d_ades(fl[2]), .d_tlbl(fl[1]), .d_tlbs(fl[0]),
        .mem_badvaddr(mem_badvaddr), .eret(eret), .interrupt_flag(interrupt_flag),
        .allow_int(allow_int), .epc(epc),
        .en_exp_o(en_exp_o), .exp_bd(exp_bd), .exp_badvaddr_we(exp_badvaddr_we),
        .clear_exl(clear_exl), .exc_code(exc_code), .exp_epc(exp_epc),
        .exp_badvaddr(exp_badvaddr), .flush(flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .redirect_ready(redirect_ready)
    );

    // mode: 0 = no action, 1 = exception, 2 = eret
    typedef struct {
        logic        mv, st;
        logic [31:0] pc;
        logic        bd;
        logic [9:0]  fl;
        logic [31:0] bva;
        logic        er;
        logic [7:0]  irq;
        logic        ai;
        logic [31:0] epc_in;
        int          mode;
        logic [4:0]  code;
        logic [31:0] xepc;
        logic        we;
        logic [31:0] xbva;
        logic [31:0] rpc;
    } vec_t;

    vec_t vt[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clr();
        mem_valid = 0; mem_stall = 0; mem_pc = 0; mem_bd = 0; fl = '0;
        mem_badvaddr = 0; eret = 0; interrupt_flag = 0; allow_int = 0; epc = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".en_exp"}, en_exp_o, 0);
        chk({tag, ".clear_exl"}, clear_exl, 0);
        chk({tag, ".flush"}, flush, 0);
        chk({tag, ".rvalid"}, redirect_valid, 0);
        chk({tag, ".rpc"}, redirect_pc, 0);
        chk({tag, ".code"}, exc_code, 0);
        chk({tag, ".we"}, exp_badvaddr_we, 0);
        chk({tag, ".epc"}, exp_epc, 0);
    endtask

    task automatic handshake(input string tag);
        redirect_ready = 1;
        step();
        chk({tag, ".hs_flush"}, flush, 0);
        chk({tag, ".hs_rvalid"}, redirect_valid, 0);
        redirect_ready = 0;
    endtask

    task automatic sys_commit(input logic [31:0] pc);
        clr(); mem_valid = 1; mem_pc = pc; fl = 10'b0001000000;
    endtask

    initial begin
        vt[0]  = '{1,0,32'h80001000,0,10'b0001000000,32'h0,0,8'h00,0,32'h0, 1,5'd8, 32'h80001000,0,32'h0,VEC};
        vt[1]  = '{1,0,32'h80002004,1,10'b0000000100,32'h3,0,8'h00,0,32'h0, 1,5'd5, 32'h80002000,1,32'h3,VEC};
        vt[2]  = '{1,0,32'h80004000,0,10'b0010000000,32'h0,0,8'h80,1,32'h0, 1,5'd0, 32'h80004000,0,32'h0,VEC};
        vt[3]  = '{1,0,32'h80006000,0,10'b0000000000,32'h0,1,8'h00,0,32'h80003000, 2,5'd0,32'h0,0,32'h0,32'h80003000};
        vt[4]  = '{1,0,32'h80007000,0,10'b0000010000,32'h0,1,8'h00,0,32'h80003000, 1,5'd12,32'h80007000,0,32'h0,VEC};
        vt[5]  = '{1,0,32'h80005001,0,10'b1000000000,32'h0,0,8'h00,0,32'h0, 1,5'd4, 32'h80005001,1,32'h80005001,VEC};
        vt[6]  = '{1,0,32'h80008000,0,10'b0110000000,32'h0,0,8'h00,0,32'h0, 1,5'd2, 32'h80008000,1,32'h80008000,VEC};
        vt[7]  = '{1,0,32'h80009000,0,10'b0010001000,32'h44,0,8'h00,0,32'h0, 1,5'd10,32'h80009000,0,32'h0,VEC};
        vt[8]  = '{1,0,32'h8000900C,0,10'b0000110000,32'h0,0,8'h00,0,32'h0, 1,5'd9, 32'h8000900C,0,32'h0,VEC};
        vt[9]  = '{1,0,32'h80009010,0,10'b0000001100,32'h12345678,0,8'h00,0,32'h0, 1,5'd4,32'h80009010,1,32'h12345678,VEC};
        vt[10] = '{1,0,32'h80009014,0,10'b0000000010,32'h0000ABCD,0,8'h00,0,32'h0, 1,5'd2,32'h80009014,1,32'h0000ABCD,VEC};
        vt[11] = '{1,0,32'h80009018,0,10'b0000000001,32'h0000FFF0,0,8'h00,0,32'h0, 1,5'd3,32'h80009018,1,32'h0000FFF0,VEC};
        vt[12] = '{1,0,32'h80009020,0,10'b0001000000,32'h0,0,8'h0F,0,32'h0, 1,5'd8, 32'h80009020,0,32'h0,VEC};
        vt[13] = '{1,0,32'h80009024,0,10'b0000100000,32'h0,0,8'h00,1,32'h0, 1,5'd9, 32'h80009024,0,32'h0,VEC};
        vt[14] = '{1,1,32'h80009028,0,10'b0001000000,32'h0,0,8'h00,0,32'h0, 0,5'd0, 32'h0,0,32'h0,32'h0};
        vt[15] = '{1,0,32'h80009028,0,10'b0001000000,32'h0,0,8'h00,0,32'h0, 1,5'd8, 32'h80009028,0,32'h0,VEC};
        vt[16] = '{0,0,32'h8000902C,0,10'b0001000000,32'h0,0,8'h00,0,32'h0, 0,5'd0, 32'h0,0,32'h0,32'h0};
        vt[17] = '{1,0,32'h00000000,1,10'b0000100000,32'h0,0,8'h00,0,32'h0, 1,5'd9, 32'hFFFFFFFC,0,32'h0,VEC};
        vt[18] = '{1,0,32'h80009030,0,10'b0000000000,32'h0,0,8'h00,1,32'h0, 0,5'd0, 32'h0,0,32'h0,32'h0};
        vt[19] = '{1,0,32'h80009034,1,10'b0000000000,32'h0,1,8'h00,0,32'h9FC00000, 2,5'd0,32'h0,0,32'h0,32'h9FC00000};

        clr(); redirect_ready = 0; rst = 1;
        #1;
        chk_all_zero("reset");
        #11 rst = 0;   // released between edges

        foreach (vt[i]) begin
            string t;
            t = $sformatf("v%0d", i);
            clr();
            mem_valid = vt[i].mv; mem_stall = vt[i].st; mem_pc = vt[i].pc; mem_bd = vt[i].bd;
            fl = vt[i].fl; mem_badvaddr = vt[i].bva; eret = vt[i].er;
            interrupt_flag = vt[i].irq; allow_int = vt[i].ai; epc = vt[i].epc_in;
            step();
            chk({t, ".en_exp"}, en_exp_o, vt[i].mode == 1);
            chk({t, ".clear_exl"}, clear_exl, vt[i].mode == 2);
            chk({t, ".flush"}, flush, vt[i].mode != 0);
            chk({t, ".rvalid"}, redirect_valid, vt[i].mode != 0);
            if (vt[i].mode != 0) chk({t, ".rpc"}, redirect_pc, vt[i].rpc);
            if (vt[i].mode == 1) begin
                chk({t, ".code"}, exc_code, vt[i].code);
                chk({t, ".bd"}, exp_bd, vt[i].bd);
                chk({t, ".epc"}, exp_epc, vt[i].xepc);
                chk({t, ".we"}, exp_badvaddr_we, vt[i].we);
                if (vt[i].we) chk({t, ".bva"}, exp_badvaddr, vt[i].xbva);
            end
            if (vt[i].mode != 0) begin
                clr();
                step();
                chk({t, ".pulse_en"}, en_exp_o, 0);
                chk({t, ".pulse_clr"}, clear_exl, 0);
                chk({t, ".pulse_we"}, exp_badvaddr_we, 0);
                chk({t, ".hold_flush"}, flush, 1);
                chk({t, ".hold_rpc"}, redirect_pc, vt[i].rpc);
                handshake(t);
            end
        end

        // interrupt deferred while no instruction is in MEM
        clr(); allow_int = 1; interrupt_flag = 8'h80; fl = 10'b0010000000;
        for (int k = 0; k < 2; k++) begin
            step();
            chk("defer.flush", flush, 0);
            chk("defer.en_exp", en_exp_o, 0);
        end
        mem_valid = 1; mem_pc = 32'h8000A000;
        step();
        chk("defer.en_exp_late", en_exp_o, 1);
        chk("defer.code", exc_code, 0);
        chk("defer.epc", exp_epc, 32'h8000A000);
        clr();
        handshake("defer");

        // redirect backpressure: held state, new commits ignored
        sys_commit(32'h8000C000);
        step();
        chk("bp.first", en_exp_o, 1);
        mem_pc = 32'h8000B000;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp.flush", flush, 1);
            chk("bp.rvalid", redirect_valid, 1);
            chk("bp.rpc", redirect_pc, VEC);
            chk("bp.en_exp", en_exp_o, 0);
            chk("bp.epc", exp_epc, 32'h8000C000);
        end
        redirect_ready = 1;
        step();
        chk("bp.release_flush", flush, 0);
        chk("bp.release_rvalid", redirect_valid, 0);
        redirect_ready = 0;
        step();
        chk("bp.next_commit", en_exp_o, 1);
        chk("bp.next_epc", exp_epc, 32'h8000B000);
        clr();
        handshake("bp");

        // asynchronous reset while redirecting
        sys_commit(32'h8000D000);
        step();
        chk("ar.pre", flush, 1);
        clr();
        #2 rst = 1;
        #1;
        chk_all_zero("ar");
        #1 rst = 0;
        sys_commit(32'h8000E000);
        step();
        chk("ar.first_commit", en_exp_o, 1);
        chk("ar.first_epc", exp_epc, 32'h8000E000);
        clr();
        handshake("ar");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
